vend_coin_arbiter: RTL and testbench
====================================

VEND_COIN_ARBITER -- requirements
Module: vend_coin_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning consecutive coin-less cycles before an owning requester is timed out (range 2..255).
REQ-002 The block SHALL have port clk, input, 1, single system clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port req0_coin, input, 2, requester 0 coin code: 00 none, 01 one rupee, 10 two rupee, 11 invalid.
REQ-005 The block SHALL have port req1_coin, input, 2, requester 1 coin code, same encoding.
REQ-006 The block SHALL have port vfsm_product, input, 1, product-dispensed pulse from the downstream vending FSM.
REQ-007 The block SHALL have port vfsm_coin, output, 2, registered coin code forwarded to the vending FSM.
REQ-008 The block SHALL have port vfsm_clr, output, 1, one-cycle pulse that clears the vending FSM credit.
REQ-009 The block SHALL have ports gnt0 and gnt1, output, 1 each, high while the respective requester owns the machine.
REQ-010 The block SHALL have ports rej0 and rej1, output, 1 each, one-cycle pulse when that requester's coin is refused.
REQ-011 The block SHALL have port credit, output, 3, running sum of forwarded coin values in the current transaction.
REQ-012 The block SHALL have ports refund_valid (output, 1) and refund_amt (output, 3), refund pulse and amount.

Function
REQ-013 The block SHALL implement states IDLE, OWN0, OWN1, REFUND; all outputs registered.
REQ-014 In IDLE, a valid coin (01/10) from exactly one requester SHALL move to OWNx of that requester and forward the coin on vfsm_coin the next cycle (latency 1).
REQ-015 In IDLE, valid coins from both requesters in the same cycle SHALL be resolved by a round-robin pointer; the loser gets rejN pulsed the next cycle.
REQ-016 The round-robin pointer SHALL point to the requester that did not own the most recent completed or timed-out transaction.
REQ-017 In OWNx, valid owner coins SHALL be forwarded with latency 1; any non-00 coin from the non-owner SHALL be refused via its rej pulse.
REQ-018 Code 11 from any requester in any state SHALL never be forwarded and SHALL pulse that requester's rej.
REQ-019 credit SHALL add 1 or 2 per forwarded coin, saturating at 7.
REQ-020 vfsm_product high in OWNx SHALL move to IDLE next cycle, clear credit, drop gntx, and update the pointer.
REQ-021 An owner coin arriving in the same cycle as vfsm_product SHALL be refused (rej pulse), not forwarded.
REQ-022 vfsm_coin SHALL be 00 in every cycle not carrying a forwarded coin.

Reset
REQ-023 Asserting rst SHALL immediately force IDLE, pointer to requester 0, credit 0, timeout counter 0, and all outputs 0.
REQ-024 Reset mid-transaction SHALL discard credit without a refund_valid or vfsm_clr pulse.

Configuration
REQ-025 With macro VEND_ARB_TIMEOUT_EN defined, a counter SHALL clear on each forwarded coin and, after TIMEOUT_CYCLES consecutive OWNx cycles without one, SHALL enter REFUND.
REQ-026 REFUND SHALL last one cycle with refund_valid=1, refund_amt=credit, vfsm_clr=1, both gnt low, all coins refused, then go to IDLE with credit 0 and pointer updated.
REQ-027 Without VEND_ARB_TIMEOUT_EN, no counter SHALL exist, REFUND SHALL be unreachable, and refund_valid, refund_amt, vfsm_clr SHALL be tied 0.

Verification
REQ-028 Single owner: req0 sends 01,01,01 on consecutive cycles, then vfsm_product=1 -> vfsm_coin shows 01 x3 one cycle later, credit 1,2,3, gnt0 drops the cycle after product.
REQ-029 Contention: from reset both send 10 in the same cycle -> gnt0=1, rej1 pulses, vfsm_coin=10; after product, both send 01 -> gnt1=1, rej0 pulses.
REQ-030 Invalid/intruder: req0 owns; req0 sends 11, req1 sends 01 -> rej0 and rej1 pulse, vfsm_coin stays 00, credit unchanged.
REQ-031 Timeout (macro on, TIMEOUT_CYCLES=4): req1 sends 10, then idles 4 cycles -> refund_valid=1, refund_amt=2, vfsm_clr=1 for one cycle, then IDLE.
REQ-032 Reset mid-transaction: req0 credit=2, rst pulsed -> all outputs 0 same cycle, no refund pulse, next req1 coin granted to req1.
REQ-033 Saturation/same-cycle product: req0 sends 10 x4 -> credit 7; 10 coincident with vfsm_product -> rej0 pulses, coin not forwarded.

Source files
------------

// File: rtl/vend_coin_arbiter.sv
// Two-requester coin arbiter in front of a vending FSM: grants ownership,
// forwards coins, and tracks credit. The idle-owner timeout with refund is
// enabled by the macro VEND_ARB_TIMEOUT_EN.
module vend_coin_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req0_coin,
  input  logic [1:0] req1_coin,
  input  logic       vfsm_product,
  output logic [1:0] vfsm_coin,
  output logic       vfsm_clr,
  output logic       gnt0,
  output logic       gnt1,
  output logic       rej0,
  output logic       rej1,
  output logic [2:0] credit,
  output logic       refund_valid,
  output logic [2:0] refund_amt
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, REFUND} state_t;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  state_t     state, state_nx;
  logic       ptr, ptr_nx;
  logic [2:0] credit_nx;
  logic [1:0] coin_nx;
  logic       rej0_nx, rej1_nx;
  logic       own;
  logic [1:0] own_coin, other_coin;
  logic       rej_own, rej_other;

`ifdef VEND_ARB_TIMEOUT_EN
  logic [7:0] cnt, cnt_nx;
  logic       refund_nx;
  logic [2:0] amt_nx;
`endif

  function automatic logic is_valid(input logic [1:0] c);
    return (c == 2'b01) || (c == 2'b10);
  endfunction

  function automatic logic [2:0] add_sat(input logic [2:0] c, input logic [1:0] coin);
    logic [3:0] s;
    s = {1'b0, c} + {2'b00, coin};
    return (s > 4'd7) ? 3'd7 : s[2:0];
  endfunction

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    credit_nx  = credit;
    coin_nx    = 2'b00;
    rej0_nx    = 1'b0;
    rej1_nx    = 1'b0;
    own        = (state == OWN1);
    own_coin   = own ? req1_coin : req0_coin;
    other_coin = own ? req0_coin : req1_coin;
    rej_own    = 1'b0;
    rej_other  = 1'b0;
`ifdef VEND_ARB_TIMEOUT_EN
    cnt_nx    = cnt;
    refund_nx = 1'b0;
    amt_nx    = 3'd0;
`endif
    case (state)
      IDLE: begin
        // Contention is settled by ptr: 0 favours requester 0.
        if (is_valid(req0_coin) && (!is_valid(req1_coin) || !ptr)) begin
          state_nx  = OWN0;
          coin_nx   = req0_coin;
          credit_nx = add_sat(3'd0, req0_coin);
          rej1_nx   = (req1_coin != 2'b00);
        end else if (is_valid(req1_coin)) begin
          state_nx  = OWN1;
          coin_nx   = req1_coin;
          credit_nx = add_sat(3'd0, req1_coin);
          rej0_nx   = (req0_coin != 2'b00);
        end else begin
          rej0_nx = (req0_coin == 2'b11);
          rej1_nx = (req1_coin == 2'b11);
        end
`ifdef VEND_ARB_TIMEOUT_EN
        cnt_nx = 8'd0;
`endif
      end
      OWN0, OWN1: begin
        rej_other = (other_coin != 2'b00);
        if (vfsm_product) begin
          // A coin racing the product pulse belongs to no transaction.
          state_nx  = IDLE;
          credit_nx = 3'd0;
          ptr_nx    = ~own;
          rej_own   = (own_coin != 2'b00);
        end else if (is_valid(own_coin)) begin
          coin_nx   = own_coin;
          credit_nx = add_sat(credit, own_coin);
`ifdef VEND_ARB_TIMEOUT_EN
          cnt_nx = 8'd0;
`endif
        end else begin
          rej_own = (own_coin == 2'b11);
`ifdef VEND_ARB_TIMEOUT_EN
          if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            state_nx  = REFUND;
            refund_nx = 1'b1;
            amt_nx    = credit;
            ptr_nx    = ~own;
            cnt_nx    = 8'd0;
          end else begin
            cnt_nx = cnt + 8'd1;
          end
`endif
        end
        rej0_nx = own ? rej_other : rej_own;
        rej1_nx = own ? rej_own : rej_other;
      end
      REFUND: begin
        state_nx  = IDLE;
        credit_nx = 3'd0;
        rej0_nx   = (req0_coin != 2'b00);
        rej1_nx   = (req1_coin != 2'b00);
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      credit    <= 3'd0;
      vfsm_coin <= 2'b00;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rej0      <= 1'b0;
      rej1      <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      credit    <= credit_nx;
      vfsm_coin <= coin_nx;
      gnt0      <= (state_nx == OWN0);
      gnt1      <= (state_nx == OWN1);
      rej0      <= rej0_nx;
      rej1      <= rej1_nx;
    end
  end

`ifdef VEND_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= 8'd0;
      refund_valid <= 1'b0;
      refund_amt   <= 3'd0;
      vfsm_clr     <= 1'b0;
    end else begin
      cnt          <= cnt_nx;
      refund_valid <= refund_nx;
      refund_amt   <= amt_nx;
      vfsm_clr     <= refund_nx;
    end
  end
`else
  assign refund_valid = 1'b0;
  assign refund_amt   = 3'd0;
  assign vfsm_clr     = 1'b0;
`endif

endmodule

// File: tb/tb_vend_coin_arbiter.sv
// Directed bench for vend_coin_arbiter; covers both builds of
// VEND_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4.
module tb_vend_coin_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req0_coin, req1_coin;
  logic       vfsm_product;
  logic [1:0] vfsm_coin;
  logic       vfsm_clr, gnt0, gnt1, rej0, rej1, refund_valid;
  logic [2:0] credit, refund_amt;

  int total = 0;
  int bad   = 0;

  vend_coin_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req0_coin(req0_coin), .req1_coin(req1_coin),
    .vfsm_product(vfsm_product),
    .vfsm_coin(vfsm_coin), .vfsm_clr(vfsm_clr),
    .gnt0(gnt0), .gnt1(gnt1), .rej0(rej0), .rej1(rej1),
    .credit(credit), .refund_valid(refund_valid), .refund_amt(refund_amt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Apply inputs for one cycle, then look at the registered result #1 after the edge.
  task automatic drive(input logic [1:0] c0, input logic [1:0] c1, input logic p);
    req0_coin    = c0;
    req1_coin    = c1;
    vfsm_product = p;
    @(posedge clk);
    #1;
    req0_coin    = 2'b00;
    req1_coin    = 2'b00;
    vfsm_product = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_coin"}, vfsm_coin, 0);
    check({tag, "_gnt"}, {gnt1, gnt0}, 0);
    check({tag, "_rej"}, {rej1, rej0}, 0);
    check({tag, "_credit"}, credit, 0);
    check({tag, "_refund"}, {refund_valid, vfsm_clr}, 0);
    check({tag, "_amt"}, refund_amt, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req0_coin = 2'b00;
    req1_coin = 2'b00;
    vfsm_product = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // single owner, three 1-rupee coins then product
    drive(2'b01, 2'b00, 1'b0);
    check("own_gnt0", gnt0, 1);
    check("own_coin1", vfsm_coin, 1);
    check("own_credit1", credit, 1);
    drive(2'b01, 2'b00, 1'b0);
    check("own_coin2", vfsm_coin, 1);
    check("own_credit2", credit, 2);
    drive(2'b01, 2'b00, 1'b0);
    check("own_coin3", vfsm_coin, 1);
    check("own_credit3", credit, 3);
    drive(2'b00, 2'b00, 1'b1);
    check("prod_gnt0", gnt0, 0);
    check("prod_credit", credit, 0);
    check("prod_coin", vfsm_coin, 0);

    // contention from reset: req0 wins, then req1 wins the rematch
    pulse_reset();
    drive(2'b10, 2'b10, 1'b0);
    check("cont_gnt", {gnt1, gnt0}, 2'b01);
    check("cont_rej", {rej1, rej0}, 2'b10);
    check("cont_coin", vfsm_coin, 2);
    check("cont_credit", credit, 2);
    drive(2'b00, 2'b00, 1'b1);
    check("cont_prod_gnt", {gnt1, gnt0}, 0);
    drive(2'b01, 2'b01, 1'b0);
    check("cont2_gnt", {gnt1, gnt0}, 2'b10);
    check("cont2_rej", {rej1, rej0}, 2'b01);
    check("cont2_coin", vfsm_coin, 1);
    drive(2'b00, 2'b00, 1'b1);
    check("cont2_prod_gnt", gnt1, 0);

    // invalid coin from owner plus intruder coin
    drive(2'b01, 2'b00, 1'b0);
    check("inv_gnt0", gnt0, 1);
    drive(2'b11, 2'b01, 1'b0);
    check("inv_rej", {rej1, rej0}, 2'b11);
    check("inv_coin", vfsm_coin, 0);
    check("inv_credit", credit, 1);
    check("inv_gnt0_hold", gnt0, 1);
    drive(2'b00, 2'b00, 1'b0);
    check("inv_rej_pulse", {rej1, rej0}, 0);
    drive(2'b00, 2'b00, 1'b1);

    // owner goes quiet for TIMEOUT_CYCLES cycles
    drive(2'b00, 2'b10, 1'b0);
    check("to_gnt1", gnt1, 1);
    check("to_credit", credit, 2);
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 2'b00, 1'b0);
      check("to_wait_refund", refund_valid, 0);
      check("to_wait_gnt1", gnt1, 1);
    end
    drive(2'b00, 2'b00, 1'b0);
`ifdef VEND_ARB_TIMEOUT_EN
    check("to_refund_valid", refund_valid, 1);
    check("to_refund_amt", refund_amt, 2);
    check("to_clr", vfsm_clr, 1);
    check("to_gnt", {gnt1, gnt0}, 0);
    drive(2'b01, 2'b00, 1'b0);
    check("to_after_refund", {refund_valid, vfsm_clr}, 0);
    check("to_after_credit", credit, 0);
    check("to_after_rej0", rej0, 1);
    check("to_after_gnt", {gnt1, gnt0}, 0);
`else
    check("to_none_refund", {refund_valid, vfsm_clr}, 0);
    check("to_none_gnt1", gnt1, 1);
    check("to_none_credit", credit, 2);
    drive(2'b01, 2'b00, 1'b0);
    check("to_none_rej0", rej0, 1);
    drive(2'b00, 2'b00, 1'b1);
    check("to_none_prod", gnt1, 0);
`endif

    // reset in the middle of a transaction
    drive(2'b10, 2'b00, 1'b0);
    check("rst_mid_credit_pre", credit, 2);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    @(posedge clk);
    #1;
    check("rst_mid_held", {refund_valid, vfsm_clr, gnt0}, 0);
    rst = 1'b0;
    drive(2'b00, 2'b01, 1'b0);
    check("rst_next_gnt", {gnt1, gnt0}, 2'b10);
    check("rst_next_credit", credit, 1);
    drive(2'b00, 2'b00, 1'b1);

    // credit saturation, then a coin racing the product pulse
    drive(2'b10, 2'b00, 1'b0);
    check("sat_credit1", credit, 2);
    drive(2'b10, 2'b00, 1'b0);
    check("sat_credit2", credit, 4);
    drive(2'b10, 2'b00, 1'b0);
    check("sat_credit3", credit, 6);
    drive(2'b10, 2'b00, 1'b0);
    check("sat_credit4", credit, 7);
    check("sat_coin4", vfsm_coin, 2);
    drive(2'b10, 2'b00, 1'b1);
    check("race_rej0", rej0, 1);
    check("race_coin", vfsm_coin, 0);
    check("race_gnt0", gnt0, 0);
    check("race_credit", credit, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
